// File: rtl/loongarch_fetch_queue_pkg.sv
// Shared types and constants for the LoongArch instruction-fetch queue.
package loongarch_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
    localparam logic [5:0]  ECODE_ADEF   = 6'h08;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
        logic        adef;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    function automatic logic [5:0] entry_ecode(input fetch_entry_t e);
        return e.adef ? ECODE_ADEF : 6'h00;
    endfunction

endpackage

// File: rtl/loongarch_fetch_queue_if.sv
// Fetch-queue signal bundle: redirect, SRAM-like instruction port and decode handshake.
interface loongarch_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adef;

    modport master (
        input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
        output inst_req, inst_addr, out_valid, out_pc, out_instr, out_adef
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
        input  inst_req, inst_addr, out_valid, out_pc, out_instr, out_adef
    );
endinterface

// File: rtl/loongarch_fetch_queue_entry_ram.sv
// DEPTH-entry fetch register file: full-entry write on alloc, instr/filled write on fill,
// async read of a whole entry (head) and of the status bits at the fill pointer.
module fetch_entry_ram
    import loongarch_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_alloc_we,
    input  logic [PTR_W-1:0]   i_alloc_idx,
    input  fetch_entry_t       i_alloc_dat,
    input  logic               i_fill_we,
    input  logic [PTR_W-1:0]   i_fill_idx,
    input  logic [31:0]        i_fill_dat,
    input  logic [PTR_W-1:0]   i_rd_idx,
    output fetch_entry_t       o_rd_dat,
    input  logic [PTR_W-1:0]   i_chk_idx,
    output logic               o_chk_filled,
    output logic               o_chk_adef
);

    fetch_entry_t r_mem [DEPTH];

    // Alloc and fill never target the same slot: fill only walks allocated, unfilled entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_alloc_we) r_mem[i_alloc_idx] <= i_alloc_dat;
            if (i_fill_we) begin
                r_mem[i_fill_idx].instr  <= i_fill_dat;
                r_mem[i_fill_idx].filled <= 1'b1;
            end
        end
    end

    assign o_rd_dat     = r_mem[i_rd_idx];
    assign o_chk_filled = r_mem[i_chk_idx].filled;
    assign o_chk_adef   = r_mem[i_chk_idx].adef;

endmodule

// File: rtl/loongarch_fetch_queue.sv
// Instruction-fetch queue: issues sequential fetches, buffers words in order, presents {pc, instr}
// to decode one cycle after data_ok; redirect flushes the queue and discards in-flight responses.
module loongarch_fetch_queue
    import loongarch_fetch_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = RESET_PC_DEF,
    localparam int          PTR_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    loongarch_fetch_queue_if.master fq
);

    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      r_fpc;
    logic             r_halt;
    logic [PTR_W-1:0] r_head, r_alloc, r_fill;
    logic [CNT_W-1:0] r_count, r_outst, r_discard;
    logic             r_out_valid;
    logic [31:0]      r_out_pc, r_out_instr;
    logic             r_out_adef;

    logic             w_space, w_can_alloc, w_req, w_accept, w_adef_alloc, w_alloc;
    logic             w_rsp, w_drop, w_fill, w_skip, w_pop, w_redir;
    logic             w_chk_filled, w_chk_adef, w_out_valid_nxt;
    logic [PTR_W-1:0] w_head_nxt;
    logic [CNT_W-1:0] w_count_nxt, w_outst_nxt;
    fetch_entry_t     w_alloc_ent, w_rd_ent, w_head_ent;

    assign w_redir      = fq.redirect_valid;
    assign w_space      = r_count < DEPTH_C;
    assign w_can_alloc  = w_space & ~r_halt & ~w_redir;
    assign w_req        = w_can_alloc & ~is_misaligned(r_fpc) & ~rst;
    assign w_accept     = w_req & fq.inst_addr_ok;
    assign w_adef_alloc = w_can_alloc & is_misaligned(r_fpc);
    assign w_alloc      = w_accept | w_adef_alloc;

    // A data_ok with nothing outstanding is a bus protocol error and is ignored.
    assign w_rsp  = fq.inst_data_ok & (r_outst != '0);
    assign w_drop = w_rsp & (r_discard != '0);
    assign w_fill = w_rsp & ~w_drop & ~w_redir;
    assign w_skip = ~w_fill & ~w_redir & (r_fill != r_alloc) & w_chk_filled & w_chk_adef;
    assign w_pop  = r_out_valid & fq.out_ready & ~w_redir;

    assign w_head_nxt  = w_redir ? '0 : r_head + PTR_W'(w_pop);
    assign w_count_nxt = w_redir ? '0 : r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    assign w_outst_nxt = r_outst + CNT_W'(w_accept) - CNT_W'(w_rsp);

    always_comb begin
        w_alloc_ent        = '0;
        w_alloc_ent.pc     = r_fpc;
        w_alloc_ent.filled = w_adef_alloc;
        w_alloc_ent.adef   = w_adef_alloc;
    end

    fetch_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk          (clk),
        .rst          (rst),
        .i_alloc_we   (w_alloc),
        .i_alloc_idx  (r_alloc),
        .i_alloc_dat  (w_alloc_ent),
        .i_fill_we    (w_fill),
        .i_fill_idx   (r_fill),
        .i_fill_dat   (fq.inst_rdata),
        .i_rd_idx     (w_head_nxt),
        .o_rd_dat     (w_rd_ent),
        .i_chk_idx    (r_fill),
        .o_chk_filled (w_chk_filled),
        .o_chk_adef   (w_chk_adef)
    );

    // Forward this cycle's writes so the registered output sees the entry as it will be next cycle.
    always_comb begin
        w_head_ent = w_rd_ent;
        if (w_fill && (r_fill == w_head_nxt)) begin
            w_head_ent.instr  = fq.inst_rdata;
            w_head_ent.filled = 1'b1;
        end
        if (w_alloc && (r_alloc == w_head_nxt)) w_head_ent = w_alloc_ent;
    end

    assign w_out_valid_nxt = ~w_redir & (w_count_nxt != '0) & w_head_ent.filled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc       <= RESET_PC;
            r_halt      <= 1'b0;
            r_head      <= '0;
            r_alloc     <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_outst     <= '0;
            r_discard   <= '0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_out_adef  <= 1'b0;
        end else begin
            r_head      <= w_head_nxt;
            r_count     <= w_count_nxt;
            r_outst     <= w_outst_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_pc    <= w_out_valid_nxt ? w_head_ent.pc    : '0;
            r_out_instr <= w_out_valid_nxt ? w_head_ent.instr : '0;
            r_out_adef  <= w_out_valid_nxt ? w_head_ent.adef  : 1'b0;
            if (w_redir) begin
                r_fpc     <= fq.redirect_pc;
                r_halt    <= 1'b0;
                r_alloc   <= '0;
                r_fill    <= '0;
                r_discard <= w_outst_nxt;
            end else begin
                if (w_accept)     r_fpc  <= r_fpc + 32'd4;
                if (w_adef_alloc) r_halt <= 1'b1;
                r_alloc   <= r_alloc + PTR_W'(w_alloc);
                r_fill    <= r_fill + PTR_W'(w_fill | w_skip);
                r_discard <= r_discard - CNT_W'(w_drop);
            end
        end
    end

    assign fq.inst_req  = w_req;
    assign fq.inst_addr = r_fpc;
    assign fq.out_valid = r_out_valid;
    assign fq.out_pc    = r_out_pc;
    assign fq.out_instr = r_out_instr;
    assign fq.out_adef  = r_out_adef;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        fq.inst_data_ok |-> (r_outst != '0));

endmodule

// File: tb/tb_loongarch_fetch_queue.sv
// Bench for loongarch_fetch_queue: in-order memory responder plus a queue-level reference model.
module tb_loongarch_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h1c00_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    loongarch_fetch_queue_if bif();

    loongarch_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bif)
    );

    typedef struct { logic [31:0] pc; bit ret; int ret_cyc; bit adef; } exp_t;
    typedef struct { logic [31:0] addr; int due; int gen; } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    logic [31:0] exp_fpc = RPC;
    bit          exp_halt = 1'b0;
    int          gen = 0;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          n_checks = 0, n_errors = 0;
    int          n_acc = 0, n_pop = 0;
    bit          arm_first = 1'b0;
    logic [31:0] first_pop_pc = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9e37_79b9;
    endfunction

    // One clock cycle: drive inputs at edge+1, check outputs at edge+2, advance model, wait for next edge+1.
    task automatic step(input bit aok, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit dok, live, can_alloc, exp_req, exp_vld, marked;
        bif.inst_addr_ok   = aok;
        bif.out_ready      = rdy;
        bif.redirect_valid = redir;
        bif.redirect_pc    = rpc;
        dok  = (bus_q.size() > 0) && (bus_q[0].due <= cyc);
        live = dok && (bus_q[0].gen == gen);
        bif.inst_data_ok = dok;
        bif.inst_rdata   = dok ? word_of(bus_q[0].addr) : 32'h0;
        #1;
        can_alloc = (exp_q.size() < DEPTH) && !exp_halt && !redir;
        exp_req   = can_alloc && (exp_fpc[1:0] == 2'b00);
        n_checks++;
        if (bif.inst_req !== exp_req) begin
            n_errors++;
            $display("FAIL inst_req cyc=%0d got=%b exp=%b", cyc, bif.inst_req, exp_req);
        end
        if (exp_req) begin
            n_checks++;
            if (bif.inst_addr !== exp_fpc) begin
                n_errors++;
                $display("FAIL inst_addr cyc=%0d got=%h exp=%h", cyc, bif.inst_addr, exp_fpc);
            end
        end
        exp_vld = (exp_q.size() > 0) && exp_q[0].ret && (exp_q[0].ret_cyc < cyc);
        n_checks++;
        if (bif.out_valid !== exp_vld) begin
            n_errors++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bif.out_valid, exp_vld);
        end
        if (exp_vld) begin
            n_checks++;
            if (bif.out_pc !== exp_q[0].pc || bif.out_adef !== exp_q[0].adef ||
                bif.out_instr !== (exp_q[0].adef ? 32'h0 : word_of(exp_q[0].pc))) begin
                n_errors++;
                $display("FAIL out_entry cyc=%0d got pc=%h instr=%h adef=%b exp pc=%h adef=%b",
                         cyc, bif.out_pc, bif.out_instr, bif.out_adef, exp_q[0].pc, exp_q[0].adef);
            end
        end else begin
            n_checks++;
            if (bif.out_instr !== 32'h0) begin
                n_errors++;
                $display("FAIL out_instr_idle cyc=%0d got=%h exp=0", cyc, bif.out_instr);
            end
        end
        if (bif.out_valid === 1'b1 && rdy && !redir) begin
            n_pop++;
            if (arm_first) begin
                first_pop_pc = bif.out_pc;
                arm_first    = 1'b0;
            end
        end
        if (redir) begin
            exp_q.delete();
            exp_fpc  = rpc;
            exp_halt = 1'b0;
            gen++;
        end else begin
            if (exp_vld && rdy) void'(exp_q.pop_front());
            if (live) begin
                marked = 1'b0;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!marked && !exp_q[i].ret) begin
                        exp_q[i].ret     = 1'b1;
                        exp_q[i].ret_cyc = cyc;
                        marked = 1'b1;
                    end
                end
            end
            if (exp_req && aok) begin
                exp_q.push_back('{exp_fpc, 1'b0, 0, 1'b0});
                exp_fpc = exp_fpc + 32'd4;
            end else if (can_alloc && exp_fpc[1:0] != 2'b00) begin
                exp_q.push_back('{exp_fpc, 1'b1, cyc, 1'b1});
                exp_halt = 1'b1;
            end
        end
        if (dok) void'(bus_q.pop_front());
        if (bif.inst_req === 1'b1 && aok) begin
            n_acc++;
            bus_q.push_back('{bif.inst_addr, cyc + int'($urandom_range(lat_max, lat_min)), gen});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.redirect_valid = 1'b0; bif.redirect_pc = '0; bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b0; bif.inst_rdata = '0; bif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bif.inst_req !== 1'b0 || bif.out_valid !== 1'b0 || bif.out_pc !== 32'h0 ||
            bif.out_instr !== 32'h0 || bif.out_adef !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs req=%b vld=%b pc=%h instr=%h adef=%b exp all 0",
                     bif.inst_req, bif.out_valid, bif.out_pc, bif.out_instr, bif.out_adef);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bif.inst_req !== 1'b1 || bif.inst_addr !== 32'h1c00_0000) begin
            n_errors++;
            $display("FAIL reset_first_fetch req=%b addr=%h exp req=1 addr=1c000000",
                     bif.inst_req, bif.inst_addr);
        end
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1;
        n_pop = 0; arm_first = 1'b1;
        repeat (16) step(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (first_pop_pc !== 32'h1c00_0000) begin
            n_errors++;
            $display("FAIL seq_first_pc got=%h exp=1c000000", first_pop_pc);
        end
        n_checks++;
        if (n_pop != 14) begin
            n_errors++;
            $display("FAIL seq_pop_count got=%0d exp=14", n_pop);
        end
    endtask

    task automatic test_full_stall();
        step(1'b0, 1'b0, 1'b1, 32'h1c00_0040);
        n_acc = 0;
        repeat (10) step(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if (n_acc != DEPTH) begin
            n_errors++;
            $display("FAIL stall_accepts got=%0d exp=%0d", n_acc, DEPTH);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (n_acc != DEPTH) begin
            n_errors++;
            $display("FAIL stall_pop_cycle_accepts got=%0d exp=%0d", n_acc, DEPTH);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (n_acc != DEPTH + 1) begin
            n_errors++;
            $display("FAIL stall_resume_accepts got=%0d exp=%0d", n_acc, DEPTH + 1);
        end
        repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect_discard();
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b1, 32'h1c00_0080);
        repeat (5) step(1'b0, 1'b1, 1'b0, '0);
        repeat (2) step(1'b1, 1'b1, 1'b0, '0);
        arm_first = 1'b1;
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
        repeat (8) step(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (first_pop_pc !== 32'h1c00_0100) begin
            n_errors++;
            $display("FAIL discard_first_pc got=%h exp=1c000100", first_pop_pc);
        end
    endtask

    task automatic test_redirect_collision();
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h1c00_0300);
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.inst_addr !== 32'h1c00_0300) begin
            n_errors++;
            $display("FAIL collision_after vld=%b addr=%h exp vld=0 addr=1c000300",
                     bif.out_valid, bif.inst_addr);
        end
        repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_misaligned();
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b0, 1'b1, 32'h1c00_0102);
        n_acc = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_adef !== 1'b1 || bif.out_pc !== 32'h1c00_0102 ||
            bif.out_instr !== 32'h0) begin
            n_errors++;
            $display("FAIL adef_entry vld=%b adef=%b pc=%h instr=%h exp 1 1 1c000102 0",
                     bif.out_valid, bif.out_adef, bif.out_pc, bif.out_instr);
        end
        repeat (5) step(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (n_acc != 0) begin
            n_errors++;
            $display("FAIL adef_halt_accepts got=%0d exp=0", n_acc);
        end
        arm_first = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h1c00_0200);
        n_acc = 0;
        repeat (6) step(1'b1, 1'b1, 1'b0, '0);
        n_checks++;
        if (n_acc != 6 || first_pop_pc !== 32'h1c00_0200) begin
            n_errors++;
            $display("FAIL adef_resume accepts=%0d first_pc=%h exp 6 1c000200", n_acc, first_pop_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit redir;
        lat_min = 1; lat_max = 4;
        n_pop = 0;
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(39, 0) == 0);
            rpc = 32'h1c00_0000 + 32'($urandom_range(255, 0)) * 32'd4 +
                  (($urandom_range(7, 0) == 0) ? 32'd2 : 32'd0);
            step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, redir, rpc);
        end
        n_checks++;
        if (n_pop <= 100) begin
            n_errors++;
            $display("FAIL random_progress pops=%0d exp >100", n_pop);
        end
    endtask

    task automatic test_reset_mid();
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b0, 1'b1, 32'h1c00_0400);
        repeat (6) step(1'b0, 1'b0, 1'b0, '0);
        repeat (4) step(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if (bif.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_buffered vld=%b exp=1", bif.out_valid);
        end
        bif.inst_addr_ok = 1'b0; bif.inst_data_ok = 1'b0; bif.out_ready = 1'b0;
        bif.redirect_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bif.inst_req !== 1'b0 || bif.out_valid !== 1'b0 || bif.out_pc !== 32'h0 ||
            bif.out_instr !== 32'h0 || bif.out_adef !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs req=%b vld=%b pc=%h instr=%h adef=%b exp all 0",
                     bif.inst_req, bif.out_valid, bif.out_pc, bif.out_instr, bif.out_adef);
        end
        bus_q.delete();
        exp_q.delete();
        exp_fpc = RPC; exp_halt = 1'b0; gen++;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        n_checks++;
        if (bif.inst_addr !== 32'h1c00_0000 || bif.inst_req !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_fetch addr=%h req=%b exp 1c000000 1", bif.inst_addr, bif.inst_req);
        end
        repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_stall();
        test_redirect_discard();
        test_redirect_collision();
        test_misaligned();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
